// File: rtl/col_encoder_rle.sv
// Zero-run / literal-pack pixel compressor with a show-ahead token FIFO and valid/ack drain.
// Optional ENC_STATS_EN adds free-running accepted-pixel and written-token counters.
module col_encoder_rle #(
    parameter int PIXEL_W    = 3,
    parameter int OUT_W      = 16,
    parameter int PACK_N     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               data_valid,
    output logic               pixel_ready,
    input  logic               flush,
    output logic [OUT_W-1:0]   encoded_dat,
    output logic               data_ready,
    input  logic               encoded_ack
`ifdef ENC_STATS_EN
    ,
    output logic [31:0]        pix_cnt,
    output logic [31:0]        tok_cnt
`endif
);

    localparam int CNT_W  = $clog2(PACK_N + 1);
    localparam int PACK_W = PACK_N * PIXEL_W;
    localparam int RUN_W  = OUT_W - 1;
    localparam int AW     = $clog2(FIFO_DEPTH);

    localparam logic [RUN_W-1:0] RUN_MAX   = '1;
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [CNT_W-1:0] PACK_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PACK_FULL = CNT_W'(PACK_N);
    localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
    localparam logic [AW:0]      CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]      FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    generate
        if (OUT_W < 1 + CNT_W + PACK_W) begin : g_bad_out_w
            $error("col_encoder_rle: OUT_W too small for PACK_N literal token");
        end
        if (PACK_N < 2) begin : g_bad_pack_n
            $error("col_encoder_rle: PACK_N must be >= 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("col_encoder_rle: FIFO_DEPTH must be a power of 2, >= 2");
        end
    endgenerate

    function automatic logic [OUT_W-1:0] f_run_tok(input logic [RUN_W-1:0] n);
        return {1'b1, n};
    endfunction

    function automatic logic [OUT_W-1:0] f_lit_tok(input logic [CNT_W-1:0] n,
                                                  input logic [PACK_W-1:0] d);
        logic [OUT_W-1:0] t;
        t = '0;
        t[OUT_W-2 -: CNT_W] = n;
        t[PACK_W-1:0]       = d;
        return t;
    endfunction

    logic [RUN_W-1:0]  r_run_cnt;
    logic [CNT_W-1:0]  r_pack_cnt;
    logic [PACK_W-1:0] r_pack_reg;
    logic [OUT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_full;

    logic              w_accept;
    logic              w_flush_take;
    logic              w_pop;
    logic              w_wr_en;
    logic [OUT_W-1:0]  w_wr_dat;
    logic [RUN_W-1:0]  w_run_n;
    logic [CNT_W-1:0]  w_pack_cnt_n;
    logic [PACK_W-1:0] w_pack_reg_n;
    logic [PACK_W-1:0] w_slot_reg;
    logic [AW:0]       w_count_n;

    // Full flag is registered so a same-edge pop never lets a pixel in early.
    assign pixel_ready  = ~r_full & ~flush;
    assign data_ready   = (r_count != '0);
    assign encoded_dat  = data_ready ? r_mem[r_rd_ptr] : '0;
    assign w_accept     = data_valid & pixel_ready;
    assign w_flush_take = flush & ~r_full;
    assign w_pop        = encoded_ack & data_ready;

    always_comb begin
        w_wr_en      = 1'b0;
        w_wr_dat     = '0;
        w_run_n      = r_run_cnt;
        w_pack_cnt_n = r_pack_cnt;
        w_pack_reg_n = r_pack_reg;
        w_slot_reg   = r_pack_reg;
        for (int s = 0; s < PACK_N; s++) begin
            if (r_pack_cnt == CNT_W'(s)) begin
                w_slot_reg[s*PIXEL_W +: PIXEL_W] = pixel_in;
            end
        end

        if (w_flush_take) begin
            if (r_run_cnt != '0) begin
                w_wr_en  = 1'b1;
                w_wr_dat = f_run_tok(r_run_cnt);
            end else if (r_pack_cnt != '0) begin
                w_wr_en  = 1'b1;
                w_wr_dat = f_lit_tok(r_pack_cnt, r_pack_reg);
            end
            w_run_n      = '0;
            w_pack_cnt_n = '0;
            w_pack_reg_n = '0;
        end else if (w_accept) begin
            if (pixel_in == '0) begin
                if (r_pack_cnt != '0) begin
                    w_wr_en      = 1'b1;
                    w_wr_dat     = f_lit_tok(r_pack_cnt, r_pack_reg);
                    w_run_n      = RUN_ONE;
                    w_pack_cnt_n = '0;
                    w_pack_reg_n = '0;
                end else if (r_run_cnt + RUN_ONE == RUN_MAX) begin
                    w_wr_en  = 1'b1;
                    w_wr_dat = f_run_tok(RUN_MAX);
                    w_run_n  = '0;
                end else begin
                    w_run_n = r_run_cnt + RUN_ONE;
                end
            end else if (r_run_cnt != '0) begin
                w_wr_en                    = 1'b1;
                w_wr_dat                   = f_run_tok(r_run_cnt);
                w_run_n                    = '0;
                w_pack_cnt_n               = PACK_ONE;
                w_pack_reg_n               = '0;
                w_pack_reg_n[PIXEL_W-1:0]  = pixel_in;
            end else if (r_pack_cnt + PACK_ONE == PACK_FULL) begin
                w_wr_en      = 1'b1;
                w_wr_dat     = f_lit_tok(PACK_FULL, w_slot_reg);
                w_pack_cnt_n = '0;
                w_pack_reg_n = '0;
            end else begin
                w_pack_cnt_n = r_pack_cnt + PACK_ONE;
                w_pack_reg_n = w_slot_reg;
            end
        end
    end

    always_comb begin
        w_count_n = r_count;
        case ({w_wr_en, w_pop})
            2'b10:   w_count_n = r_count + CNT_ONE;
            2'b01:   w_count_n = r_count - CNT_ONE;
            default: w_count_n = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt  <= '0;
            r_pack_cnt <= '0;
            r_pack_reg <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
        end else begin
            r_run_cnt  <= w_run_n;
            r_pack_cnt <= w_pack_cnt_n;
            r_pack_reg <= w_pack_reg_n;
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count    <= w_count_n;
            r_full     <= (w_count_n == FIFO_FULL);
        end
    end

    // Storage needs no reset: encoded_dat is gated by data_ready.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_dat;
    end

`ifdef ENC_STATS_EN
    logic [31:0] r_pix_cnt;
    logic [31:0] r_tok_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt <= '0;
            r_tok_cnt <= '0;
        end else begin
            if (w_accept) r_pix_cnt <= r_pix_cnt + 32'd1;
            if (w_wr_en)  r_tok_cnt <= r_tok_cnt + 32'd1;
        end
    end

    assign pix_cnt = r_pix_cnt;
    assign tok_cnt = r_tok_cnt;
`endif

endmodule

// File: tb/tb_col_encoder_rle.sv
// Bench for col_encoder_rle: token-queue reference model checked every negedge, plus
// hand-computed token literals for the directed scenarios.
module tb_col_encoder_rle;
    localparam int PIXEL_W    = 3;
    localparam int OUT_W      = 16;
    localparam int PACK_N     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(PACK_N + 1);
    localparam int RUN_MAX    = (1 << (OUT_W - 1)) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [PIXEL_W-1:0] pixel_in = '0;
    logic               data_valid = 1'b0;
    logic               flush = 1'b0;
    logic               encoded_ack = 1'b0;
    logic               pixel_ready;
    logic [OUT_W-1:0]   encoded_dat;
    logic               data_ready;
`ifdef ENC_STATS_EN
    logic [31:0]        pix_cnt;
    logic [31:0]        tok_cnt;
`endif

    col_encoder_rle #(
        .PIXEL_W(PIXEL_W), .OUT_W(OUT_W), .PACK_N(PACK_N), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .data_valid(data_valid),
        .pixel_ready(pixel_ready), .flush(flush), .encoded_dat(encoded_dat),
        .data_ready(data_ready), .encoded_ack(encoded_ack)
`ifdef ENC_STATS_EN
        , .pix_cnt(pix_cnt), .tok_cnt(tok_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mq[$];
    int lit[$];
    int log_q[$];
    int zr = 0;
    bit m_full, m_acc, m_ft, m_pop;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int run_val(input int n);
        return (1 << (OUT_W - 1)) + n;
    endfunction

    function automatic int lit_val(input int px[$]);
        int v;
        v = px.size() << (OUT_W - 1 - CNT_W);
        foreach (px[i]) v += px[i] << (i * PIXEL_W);
        return v;
    endfunction

    // Reference: tokens straight from the run/pack rules, FIFO as a plain queue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            lit.delete();
            zr = 0;
        end else begin
            m_full = (mq.size() == FIFO_DEPTH);
            m_acc  = data_valid && !m_full && !flush;
            m_ft   = flush && !m_full;
            m_pop  = encoded_ack && (mq.size() > 0);
            if (m_pop) void'(mq.pop_front());
            if (m_ft) begin
                if (zr > 0) mq.push_back(run_val(zr));
                else if (lit.size() > 0) mq.push_back(lit_val(lit));
                zr = 0;
                lit.delete();
            end else if (m_acc) begin
                if (pixel_in == '0) begin
                    if (lit.size() > 0) begin
                        mq.push_back(lit_val(lit));
                        lit.delete();
                        zr = 1;
                    end else begin
                        zr++;
                        if (zr == RUN_MAX) begin
                            mq.push_back(run_val(RUN_MAX));
                            zr = 0;
                        end
                    end
                end else begin
                    if (zr > 0) begin
                        mq.push_back(run_val(zr));
                        zr = 0;
                    end
                    lit.push_back(int'(pixel_in));
                    if (lit.size() == PACK_N) begin
                        mq.push_back(lit_val(lit));
                        lit.delete();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("data_ready", 32'(data_ready), 32'(mq.size() != 0));
        chk("encoded_dat", 32'(encoded_dat), (mq.size() != 0) ? mq[0] : 0);
        chk("pixel_ready", 32'(pixel_ready), 32'((mq.size() != FIFO_DEPTH) && !flush));
        if (rst_n && data_ready && encoded_ack) log_q.push_back(int'(encoded_dat));
    end

    task automatic send(input int p);
        bit ok;
        ok = 1'b0;
        pixel_in   = PIXEL_W'(p);
        data_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = pixel_ready;
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
        chk("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic do_flush();
        bit ok;
        ok = 1'b0;
        flush = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = (mq.size() != FIFO_DEPTH);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        chk("flush_taken", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string nm, input int exp[$]);
        chk({nm, "_count"}, 32'(log_q.size()), 32'(exp.size()));
        if (log_q.size() == exp.size())
            foreach (exp[i]) chk(nm, 32'(log_q[i]), 32'(exp[i]));
    endtask

    logic [OUT_W-1:0] hold;

    initial begin
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_data_ready", 32'(data_ready), 32'd0);
        chk("reset_encoded_dat", 32'(encoded_dat), 32'd0);
        chk("reset_pixel_ready", 32'(pixel_ready), 32'd1);

        // Full pack of four literals
        encoded_ack = 1'b1;
        log_q.delete();
        send(5); send(3); send(1); send(7);
        chk("pack4_latency", 32'(data_ready), 32'd1);
        chk("pack4_head", 32'(encoded_dat), 32'h4E5D);
        idle(3);
        chk_log("pack4", '{32'h4E5D});

        // Literal / run / literal split
        log_q.delete();
        send(2); send(0); send(0); send(0); send(6);
        do_flush();
        idle(4);
        chk_log("mixed", '{32'h1002, 32'h8003, 32'h1006});

        // Run saturation at RUN_MAX
        log_q.delete();
        for (int i = 0; i < 65500; i++) send(0);
        do_flush();
        idle(4);
        chk_log("run_sat", '{32'hFFFF, 32'hFFDD});

        // Backpressure: FIFO fills after 16 pixels with ack low
        encoded_ack = 1'b0;
        log_q.delete();
        for (int i = 0; i < 16; i++) send((i % 7) + 1);
        pixel_in   = 3'd5;
        data_valid = 1'b1;
        @(negedge clk);
        chk("bp_stall", 32'(pixel_ready), 32'd0);
        hold = encoded_dat;
        chk("bp_head", 32'(hold), 32'h48D1);
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall_hold", 32'(pixel_ready), 32'd0);
            chk("bp_dat_stable", 32'(encoded_dat), 32'(hold));
        end
        @(posedge clk);
        #1 encoded_ack = 1'b1;
        @(negedge clk);
        chk("bp_still_full", 32'(pixel_ready), 32'd0);
        @(negedge clk);
        chk("bp_resume", 32'(pixel_ready), 32'd1);
        @(posedge clk);
        #1 data_valid = 1'b0;
        do_flush();
        idle(8);
        chk_log("bp_drain", '{32'h48D1, 32'h43F5, 32'h4B1A, 32'h447E, 32'h1005});

        // Flush with nothing pending, and flush together with a valid pixel
        log_q.delete();
        flush      = 1'b1;
        data_valid = 1'b1;
        pixel_in   = 3'd3;
        @(negedge clk);
        chk("flush_blocks_pixel", 32'(pixel_ready), 32'd0);
        @(posedge clk);
        #1;
        flush      = 1'b0;
        data_valid = 1'b0;
        idle(3);
        chk("empty_flush_no_tok", 32'(data_ready), 32'd0);
        do_flush();
        idle(3);
        chk_log("empty_flush", '{});
        send(3);
        do_flush();
        idle(4);
        chk_log("after_flush_pixel", '{32'h1003});

        // Reset in the middle of a zero run with a token still queued
        encoded_ack = 1'b0;
        send(4);
        do_flush();
        for (int i = 0; i < 5; i++) send(0);
        chk("pre_reset_ready", 32'(data_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_ready", 32'(data_ready), 32'd0);
        chk("mid_reset_dat", 32'(encoded_dat), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        log_q.delete();
        encoded_ack = 1'b1;
        send(4);
        do_flush();
        idle(4);
        chk_log("post_reset", '{32'h1004});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
